// File: rtl/uart_rx_if.sv
// Stream handshake carrying received words out of uart_rx.
// The receiver drives data/valid through the master modport; the consumer
// answers with ready through the slave modport.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] output_axis_tdata;
    logic                  output_axis_tvalid;
    logic                  output_axis_tready;

    modport master (
        output output_axis_tdata,
        output output_axis_tvalid,
        input  output_axis_tready
    );

    modport slave (
        input  output_axis_tdata,
        input  output_axis_tvalid,
        output output_axis_tready
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style asynchronous serial receiver with a stream output.
// Bit period is prescale*8 clk cycles, captured at start-bit detection so a
// prescale change never disturbs a frame already in flight.
// Optional build macro UART_RX_MAJORITY_EN: each start/data/stop decision is
// the 2-of-3 majority of the synchronized line over the last three cycles of
// the bit (counter 2, 1, 0) instead of the single value at counter 0.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] prescale,
    uart_rx_if.master   m_axis,
    output logic        busy,
    output logic        overrun_error,
    output logic        frame_error
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    logic                  rxd_meta_reg;
    logic                  rxs_reg;
    logic                  sample;

    state_t                state_reg, state_next;
    logic [18:0]           period_reg, period_next;
    logic [18:0]           count_reg, count_next;
    logic [3:0]            bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] shift_ins;
    logic [DATA_WIDTH-1:0] tdata_reg, tdata_next;
    logic                  tvalid_reg, tvalid_next;
    logic                  busy_reg, busy_next;
    logic                  overrun_reg, overrun_next;
    logic                  frame_err_reg, frame_err_next;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_reg <= 1'b1;
            rxs_reg      <= 1'b1;
        end else begin
            rxd_meta_reg <= rxd;
            rxs_reg      <= rxd_meta_reg;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_reg;

    // History of the two cycles preceding the decision point (counter 2 and 1).
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg <= 2'b11;
        end else begin
            hist_reg <= {hist_reg[0], rxs_reg};
        end
    end

    assign sample = (hist_reg[1] & hist_reg[0]) |
                    (hist_reg[1] & rxs_reg)     |
                    (hist_reg[0] & rxs_reg);
`else
    assign sample = rxs_reg;
`endif

    // Shift register input: new bit enters at the MSB, so after DATA_WIDTH
    // samples the first (LSB-first) bit sits at bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
            if (gi == DATA_WIDTH - 1) begin : g_top
                assign shift_ins[gi] = sample;
            end else begin : g_low
                assign shift_ins[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= WAIT_HIGH;
            period_reg    <= '0;
            count_reg     <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            tdata_reg     <= '0;
            tvalid_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            period_reg    <= period_next;
            count_reg     <= count_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            tdata_reg     <= tdata_next;
            tvalid_reg    <= tvalid_next;
            busy_reg      <= busy_next;
            overrun_reg   <= overrun_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Next-state logic: bit timing, sampling, word hand-off and error pulses.
    always_comb begin
        state_next     = state_reg;
        period_next    = period_reg;
        count_next     = (count_reg != 19'd0) ? count_reg - 19'd1 : count_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        tdata_next     = tdata_reg;
        tvalid_next    = tvalid_reg && !m_axis.output_axis_tready;
        busy_next      = busy_reg;
        overrun_next   = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (prescale != 16'd0 && !rxs_reg) begin
                    period_next = {prescale, 3'b000};
                    count_next  = {1'b0, prescale, 2'b00} - 19'd1;
                    busy_next   = 1'b1;
                    state_next  = START;
                end
            end
            START: begin
                if (count_reg == 19'd0) begin
                    if (!sample) begin
                        count_next   = period_reg - 19'd1;
                        bit_cnt_next = 4'd0;
                        state_next   = DATA;
                    end else begin
                        // Glitch rather than a real start bit: quietly give up.
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (count_reg == 19'd0) begin
                    shift_next = shift_ins;
                    count_next = period_reg - 19'd1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            STOP: begin
                if (count_reg == 19'd0) begin
                    if (sample) begin
                        // A word accepted this same cycle is not an overrun.
                        overrun_next = tvalid_reg && !m_axis.output_axis_tready;
                        tdata_next   = shift_reg;
                        tvalid_next  = 1'b1;
                        busy_next    = 1'b0;
                        state_next   = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line is idle so a break reports only once.
                if (rxs_reg) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = WAIT_HIGH;
            end
        endcase
    end

    assign m_axis.output_axis_tdata  = tdata_reg;
    assign m_axis.output_axis_tvalid = tvalid_reg;
    assign busy                      = busy_reg;
    assign overrun_error             = overrun_reg;
    assign frame_error               = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed scenarios plus randomized frames, with a
// scoreboard queue filled by the stimulus and drained by a monitor.
module tb_uart_rx;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] prescale = 16'd1;
    logic        busy;
    logic        overrun_error;
    logic        frame_error;

    uart_rx_if #(.DATA_WIDTH(DW)) axis_if ();

    uart_rx #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .prescale      (prescale),
        .m_axis        (axis_if.master),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
        bit            chk_due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fe_seen = 0, ov_seen = 0, fe_exp = 0, ov_exp = 0;
    bit   model_tready_low = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame. Must be called just after a clock edge (edge c).
    // Expected timing: 2 sync flops + 1 detect cycle, half a bit to the start
    // centre, then DATA_WIDTH+1 full bits to the stop centre; tvalid follows it.
    task automatic send_frame(input logic [DW-1:0] data, input logic stop_bit,
                              input int hold_low, input int spike_bit, input bit scramble_ps);
        int          bp = int'(prescale) * 8;
        int unsigned c = cyc;
        logic [15:0] ps_saved = prescale;
        exp_t        e;
        rxd = 1'b0;
        if (stop_bit) begin
            e.data    = data;
            e.due     = c + 3 + bp / 2 + (DW + 1) * bp;
            e.chk_due = !model_tready_low;
            if (model_tready_low && exp_q.size() > 0) begin
                exp_q[exp_q.size() - 1] = e;   // unread word is lost
                ov_exp++;
            end else begin
                exp_q.push_back(e);
            end
        end else begin
            fe_exp++;
        end
        if (scramble_ps) begin
            wait_cycles(4);
            prescale = 16'($urandom_range(0, 65535));
            wait_cycles(bp - 4);
        end else begin
            wait_cycles(bp);
        end
        for (int i = 0; i < DW; i++) begin
            rxd = data[i];
            if (spike_bit == i) begin
                wait_cycles(bp / 2);
                rxd = ~data[i];
                wait_cycles(1);
                rxd = data[i];
                wait_cycles(bp - bp / 2 - 1);
            end else begin
                wait_cycles(bp);
            end
        end
        rxd = stop_bit;
        wait_cycles(bp + hold_low);
        rxd = 1'b1;
        prescale = ps_saved;
    endtask

    // Monitor: counts error pulse cycles and checks each accepted word.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (frame_error) fe_seen++;
            if (overrun_error) ov_seen++;
            if (axis_if.output_axis_tvalid && axis_if.output_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got tdata=%0h, required no word", axis_if.output_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    $display("rx word %02h at cycle %0d (expected %02h)", axis_if.output_axis_tdata, cyc, e.data);
                    check("word_data", 32'(axis_if.output_axis_tdata), 32'(e.data));
                    if (e.chk_due) check("word_latency", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        bit   saw;
        int   ps_r;
        logic stp;
        int   hl;
        bit   scr;
        int unsigned c;

        axis_if.output_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(axis_if.output_axis_tvalid), 0);
        check("rst_tdata", 32'(axis_if.output_axis_tdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun_error), 0);
        check("rst_frame_error", 32'(frame_error), 0);
        rst = 1'b0;

        // Basic frame at 8 clk/bit
        prescale = 16'd1;
        wait_cycles(10);
        send_frame(8'hA5, 1'b1, 0, -1, 1'b0);
        wait_cycles(10);
        check("a5_received", exp_q.size(), 0);
        check("a5_no_fe", fe_seen, 0);
        check("a5_no_ov", ov_seen, 0);

        // 3-clk glitch on an idle line
        rxd = 1'b0;
        wait_cycles(3);
        rxd = 1'b1;
        saw = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) saw = 1;
            wait_cycles(1);
        end
        check("glitch_busy_seen", 32'(saw), 1);
        wait_cycles(10);
        check("glitch_busy_low", 32'(busy), 0);
        check("glitch_no_tvalid", 32'(axis_if.output_axis_tvalid), 0);
        check("glitch_no_fe", fe_seen, 0);

        // Bad stop bit at 16 clk/bit, then a long break
        prescale = 16'd2;
        wait_cycles(10);
        send_frame(8'h3C, 1'b0, 0, -1, 1'b0);
        wait_cycles(6);
        check("fe_busy_low", 32'(busy), 0);
        check("fe_tvalid_low", 32'(axis_if.output_axis_tvalid), 0);
        check("fe_count", fe_seen, fe_exp);
        wait_cycles(10);
        send_frame(8'h00, 1'b0, 80, -1, 1'b0);
        wait_cycles(6);
        check("break_single_fe", fe_seen, fe_exp);
        check("break_busy_low", 32'(busy), 0);

        // Overrun: consumer stalled across two words
        prescale = 16'd1;
        axis_if.output_axis_tready = 1'b0;
        model_tready_low = 1;
        wait_cycles(10);
        send_frame(8'h11, 1'b1, 0, -1, 1'b0);
        wait_cycles(4);
        send_frame(8'h22, 1'b1, 0, -1, 1'b0);
        wait_cycles(10);
        check("ovr_tvalid", 32'(axis_if.output_axis_tvalid), 1);
        check("ovr_tdata", 32'(axis_if.output_axis_tdata), 32'h22);
        check("ovr_count", ov_seen, ov_exp);
        axis_if.output_axis_tready = 1'b1;
        model_tready_low = 0;
        wait_cycles(3);
        check("ovr_drained", exp_q.size(), 0);

        // Acceptance coinciding with a new word: no overrun
        axis_if.output_axis_tready = 1'b0;
        model_tready_low = 1;
        wait_cycles(5);
        send_frame(8'h33, 1'b1, 0, -1, 1'b0);
        wait_cycles(4);
        model_tready_low = 0;
        c = cyc;
        fork
            send_frame(8'h44, 1'b1, 0, -1, 1'b0);
            begin
                wait_cycles(2 + 4 + 9 * 8);
                axis_if.output_axis_tready = 1'b1;
            end
        join
        wait_cycles(5);
        check("same_cycle_drained", exp_q.size(), 0);
        check("same_cycle_no_ov", ov_seen, ov_exp);
        check("same_cycle_start", c + 78 <= cyc, 1);

        // Reset during data bit 4
        wait_cycles(5);
        rxd = 1'b0;
        wait_cycles(8);
        rxd = 1'b1;
        wait_cycles(32);
        rxd = 1'b0;
        wait_cycles(4);
        rst = 1'b1;
        rxd = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(20);
        check("midrst_tvalid", 32'(axis_if.output_axis_tvalid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_fe", fe_seen, fe_exp);
        check("midrst_ov", ov_seen, ov_exp);
        send_frame(8'h5A, 1'b1, 0, -1, 1'b0);
        wait_cycles(10);
        check("midrst_next_word", exp_q.size(), 0);

`ifdef UART_RX_MAJORITY_EN
        // Single-cycle spike at the centre of bit 2 is voted out
        wait_cycles(5);
        send_frame(8'hFF, 1'b1, 0, 2, 1'b0);
        wait_cycles(10);
        check("majority_word", exp_q.size(), 0);
`endif

        // Randomized frames, prescale scrambled mid-frame at random
        for (int n = 0; n < 40; n++) begin
            ps_r = $urandom_range(1, 3);
            stp  = ($urandom_range(0, 5) != 0);
            hl   = stp ? 0 : $urandom_range(0, 20);
            scr  = 1'($urandom_range(0, 1));
            prescale = 16'(ps_r);
            wait_cycles($urandom_range(4, 30));
            send_frame(8'($urandom), stp, hl, -1, scr);
        end
        wait_cycles(20);
        check("final_fe", fe_seen, fe_exp);
        check("final_ov", ov_seen, ov_exp);
        check("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
